// File: rtl/eth_pkg.sv
// eth_pkg: constants and CRC helper shared by the raw-Ethernet transmitter and receiver
package eth_pkg;
   localparam int          PAYLOAD_LEN = 1024;
   localparam int          HDR_LEN     = 16;
   localparam int          FCS_LEN     = 4;
   localparam logic [47:0] MAC_DST     = 48'h5965239093d4;
   localparam logic [15:0] ETYPE       = 16'h1919;
   localparam logic [7:0]  PRE_BYTE    = 8'h55;
   localparam logic [7:0]  SFD_BYTE    = 8'hd5;
   localparam logic [31:0] CRC_POLY    = 32'hedb88320;
   localparam logic [31:0] CRC_INIT    = 32'hffffffff;
   localparam logic [31:0] CRC_RESIDUE = 32'hdebb20e3;

   typedef enum logic [2:0] {WAIT_IDLE, IDLE, PRE, HDR, PAY, FCS, CHECK, DROP} rx_state_t;

   // Reflected CRC-32, one byte consumed LSB first; no final inversion.
   function automatic logic [31:0] crc32(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc ^ {24'h0, d};
      for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC_POLY : c >> 1;
      return c;
   endfunction
endpackage

// File: rtl/eth_rx_if.sv
// eth_rx_if: RGMII-style receive pins plus the payload write port and frame status
interface eth_rx_if;
   import eth_pkg::*;
   localparam int AW = $clog2(PAYLOAD_LEN) + 1;
   logic          rxctl;
   logic [3:0]    rxd;
   logic          wr_en;
   logic [AW-1:0] wr_ad;
   logic [7:0]    wr_data;
   logic          idx;
   logic [15:0]   seq;
   logic          frame_ok;
   logic [15:0]   crc_err_cnt;
   logic [15:0]   drop_cnt;
   modport master (input rxctl, rxd,
                   output wr_en, wr_ad, wr_data, idx, seq, frame_ok, crc_err_cnt, drop_cnt);
   modport slave  (output rxctl, rxd,
                   input wr_en, wr_ad, wr_data, idx, seq, frame_ok, crc_err_cnt, drop_cnt);
endinterface

// File: rtl/rgmii_rx_cap.sv
// rgmii_rx_cap: rebuilds one byte per clk125 cycle from the 4-bit DDR receive pins
module rgmii_rx_cap (
   input  logic       clk125,
   input  logic       rst_n,
   input  logic       rxctl,
   input  logic [3:0] rxd,
   output logic [7:0] rx_byte,
   output logic       byte_vld,
   output logic       rx_er
);
   logic [3:0] lo_nib;
   logic       dv;
   always_ff @(negedge clk125 or negedge rst_n)
      if (!rst_n) begin
         lo_nib <= '0;
         dv     <= 1'b0;
      end else begin
         lo_nib <= rxd;
         dv     <= rxctl;
      end
   // Second-phase rxctl carries DV^ER, so a differing phase flags an error.
   always_ff @(posedge clk125 or negedge rst_n)
      if (!rst_n) begin
         rx_byte  <= '0;
         byte_vld <= 1'b0;
         rx_er    <= 1'b0;
      end else begin
         rx_byte  <= {rxd, lo_nib};
         byte_vld <= dv;
         rx_er    <= dv ^ rxctl;
      end
endmodule

// File: rtl/eth_rx.sv
// eth_rx: validates received frames and publishes good payloads into a ping-pong buffer
module eth_rx
   import eth_pkg::*;
(
   input  logic      clk125,
   input  logic      rst_n,
   eth_rx_if.master  bus
);
   localparam int KW = $clog2(PAYLOAD_LEN);

   logic [7:0]  rx_byte;
   logic        byte_vld, rx_er;
   rx_state_t   state, state_n;
   logic [10:0] cnt, cnt_n;
   logic [31:0] crc, crc_n;
   logic [15:0] seq_tmp, seq_tmp_n;
   logic        extra, extra_n;
   logic        wr_go, ok_go, drop_inc, crc_inc, hdr_bad;
   logic [7:0]  dst_b;

   rgmii_rx_cap u_cap (
      .clk125   (clk125),
      .rst_n    (rst_n),
      .rxctl    (bus.rxctl),
      .rxd      (bus.rxd),
      .rx_byte  (rx_byte),
      .byte_vld (byte_vld),
      .rx_er    (rx_er)
   );

   // Header byte n: 1..6 destination (low byte first), 13..14 EtherType (high byte first).
   assign dst_b   = 8'(MAC_DST >> {cnt[2:0] - 3'd1, 3'b000});
   assign hdr_bad = cnt <= 11'd6  ? rx_byte != dst_b :
                    cnt == 11'd13 ? rx_byte != ETYPE[15:8] :
                    cnt == 11'd14 ? rx_byte != ETYPE[7:0] : 1'b0;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      crc_n     = crc;
      seq_tmp_n = seq_tmp;
      extra_n   = extra;
      wr_go     = 1'b0;
      ok_go     = 1'b0;
      drop_inc  = 1'b0;
      crc_inc   = 1'b0;
      case (state)
         WAIT_IDLE: if (!byte_vld) state_n = IDLE;
         IDLE:      if (byte_vld) state_n = rx_byte == PRE_BYTE ? PRE : DROP;
         PRE: begin
            state_n = byte_vld && rx_byte == PRE_BYTE ? PRE :
                      byte_vld && rx_byte == SFD_BYTE ? HDR : IDLE;
            crc_n   = CRC_INIT;
            cnt_n   = 11'd1;
         end
         HDR, PAY, FCS: begin
            crc_n = crc32(crc, rx_byte);
            cnt_n = cnt + 11'd1;
            if (!byte_vld || rx_er) begin
               drop_inc = 1'b1;
               state_n  = byte_vld ? DROP : IDLE;
            end else if (state == HDR) begin
               seq_tmp_n = cnt == 11'd15 ? {seq_tmp[15:8], rx_byte} :
                           cnt == 11'd16 ? {rx_byte, seq_tmp[7:0]} : seq_tmp;
               if (hdr_bad) begin
                  drop_inc = 1'b1;
                  state_n  = DROP;
               end else if (cnt == 11'(HDR_LEN)) begin
                  state_n = PAY;
                  cnt_n   = '0;
               end
            end else if (state == PAY) begin
               wr_go = 1'b1;
               if (cnt == 11'(PAYLOAD_LEN - 1)) begin
                  state_n = FCS;
                  cnt_n   = '0;
               end
            end else if (cnt == 11'(FCS_LEN - 1)) begin
               state_n = CHECK;
               cnt_n   = '0;
            end
         end
         // Two cycles: any valid byte seen in either marks the frame overlong.
         CHECK: begin
            extra_n = extra | byte_vld;
            cnt_n   = cnt + 11'd1;
            if (cnt[0]) begin
               extra_n = 1'b0;
               if (extra || byte_vld) begin
                  drop_inc = 1'b1;
                  state_n  = DROP;
               end else if (crc == CRC_RESIDUE) begin
                  ok_go   = 1'b1;
                  state_n = IDLE;
               end else begin
                  crc_inc = 1'b1;
                  state_n = DROP;
               end
            end
         end
         DROP:      if (!byte_vld) state_n = IDLE;
         default:   state_n = WAIT_IDLE;
      endcase
   end

   always_ff @(posedge clk125 or negedge rst_n)
      if (!rst_n) begin
         state   <= WAIT_IDLE;
         cnt     <= '0;
         crc     <= CRC_INIT;
         seq_tmp <= '0;
         extra   <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         crc     <= crc_n;
         seq_tmp <= seq_tmp_n;
         extra   <= extra_n;
      end

   // Payload always lands in the bank not currently published.
   always_ff @(posedge clk125 or negedge rst_n)
      if (!rst_n) begin
         bus.wr_en   <= 1'b0;
         bus.wr_ad   <= '0;
         bus.wr_data <= '0;
      end else begin
         bus.wr_en <= wr_go;
         if (wr_go) begin
            bus.wr_ad   <= {~bus.idx, cnt[KW-1:0]};
            bus.wr_data <= rx_byte;
         end
      end

   always_ff @(posedge clk125 or negedge rst_n)
      if (!rst_n) begin
         bus.idx         <= 1'b0;
         bus.seq         <= '0;
         bus.frame_ok    <= 1'b0;
         bus.crc_err_cnt <= '0;
         bus.drop_cnt    <= '0;
      end else begin
         bus.frame_ok <= ok_go;
         if (ok_go) begin
            bus.idx <= ~bus.idx;
            bus.seq <= seq_tmp;
         end
         if (crc_inc && bus.crc_err_cnt != 16'hffff) bus.crc_err_cnt <= bus.crc_err_cnt + 16'd1;
         if (drop_inc && bus.drop_cnt != 16'hffff) bus.drop_cnt <= bus.drop_cnt + 16'd1;
      end
endmodule

// File: tb/tb_eth_rx.sv
// tb_eth_rx: random and directed frames against a frame-level reference model with a write/frame_ok scoreboard
module tb_eth_rx;
   localparam int NONE = 100000;
   logic clk125 = 1'b0;
   logic rst_n  = 1'b0;
   eth_rx_if bus();
   eth_rx dut (.clk125(clk125), .rst_n(rst_n), .bus(bus));
   always #4 clk125 = ~clk125;

   typedef struct packed {logic [10:0] ad; logic [7:0] d;} wr_t;
   wr_t         wq[$];
   logic [16:0] okq[$];
   logic [7:0]  fr[$];
   wr_t         we;
   logic [16:0] oe;
   int          n_vec = 0, n_err = 0;
   bit          loose = 1'b0;
   logic        m_idx = 1'b0;
   logic [15:0] m_seq = '0, m_drop = '0, m_crc = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Ethernet FCS over DST..payload computed one bit at a time.
   function automatic logic [31:0] ref_fcs();
      logic [31:0] c;
      logic        fb;
      c = '1;
      for (int i = 8; i < 1048; i++)
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ fr[i][b];
            c  = {1'b0, c[31:1]} ^ (fb ? 32'hedb88320 : 32'h0);
         end
      return ~c;
   endfunction

   task automatic build(input logic [15:0] s, input logic [7:0] dst_last, input logic [7:0] et_lo, input bit rnd);
      logic [31:0] f;
      fr = {};
      repeat (7) fr.push_back(8'h55);
      fr.push_back(8'hd5);
      fr.push_back(8'hd4); fr.push_back(8'h93); fr.push_back(8'h90);
      fr.push_back(8'h23); fr.push_back(8'h65); fr.push_back(dst_last);
      repeat (6) fr.push_back(8'h66);
      fr.push_back(8'h19); fr.push_back(et_lo);
      fr.push_back(s[7:0]); fr.push_back(s[15:8]);
      for (int k = 0; k < 1024; k++) fr.push_back(rnd ? 8'($urandom) : 8'(k));
      f = ref_fcs();
      for (int i = 0; i < 4; i++) fr.push_back(f[8*i +: 8]);
   endtask

   // Expected outcome of sending the first 'sent' wire bytes with an error on byte er_at.
   task automatic predict(input int sent, input int er_at);
      logic [47:0] mac;
      int          lim;
      bit          hdr_ok;
      mac    = 48'h5965239093d4;
      lim    = (er_at < sent) ? er_at : sent;
      hdr_ok = fr[20] == 8'h19 && fr[21] == 8'h19;
      for (int i = 0; i < 6; i++) if (fr[8+i] != mac[8*i +: 8]) hdr_ok = 1'b0;
      if (!hdr_ok) begin
         m_drop++;
         return;
      end
      for (int k = 0; k < 1024 && 24 + k < lim; k++) wq.push_back({~m_idx, 10'(k), fr[24+k]});
      if (lim < 1052 || sent > 1052) m_drop++;
      else if ({fr[1051], fr[1050], fr[1049], fr[1048]} != ref_fcs()) m_crc++;
      else begin
         m_idx = ~m_idx;
         m_seq = {fr[23], fr[22]};
         okq.push_back({m_idx, m_seq});
      end
   endtask

   task automatic reset_chk();
      chk("rst_wr_en", bus.wr_en, 0);
      chk("rst_wr_ad", bus.wr_ad, 0);
      chk("rst_wr_data", bus.wr_data, 0);
      chk("rst_idx", bus.idx, 0);
      chk("rst_seq", bus.seq, 0);
      chk("rst_frame_ok", bus.frame_ok, 0);
      chk("rst_crc_err_cnt", bus.crc_err_cnt, 0);
      chk("rst_drop_cnt", bus.drop_cnt, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk125); #1;
         bus.rxctl = 1'b0; bus.rxd = 4'h0;
         @(negedge clk125); #1;
         bus.rxctl = 1'b0; bus.rxd = 4'h0;
      end
   endtask

   task automatic send(input int sent, input int er_at, input int rst_at);
      logic [7:0] b;
      for (int i = 0; i < sent; i++) begin
         b = i < fr.size() ? fr[i] : 8'haa;
         @(posedge clk125); #1;
         if (i == rst_at) rst_n = 1'b0;
         if (i == rst_at + 3) rst_n = 1'b1;
         bus.rxd = b[3:0]; bus.rxctl = 1'b1;
         @(negedge clk125); #1;
         bus.rxd = b[7:4]; bus.rxctl = (i == er_at) ? 1'b0 : 1'b1;
         if (i == rst_at) reset_chk();
      end
      idle(12);
   endtask

   task automatic frame_end(input string tag);
      chk({tag, "_idx"}, bus.idx, m_idx);
      chk({tag, "_seq"}, bus.seq, m_seq);
      chk({tag, "_crc_err_cnt"}, bus.crc_err_cnt, m_crc);
      chk({tag, "_drop_cnt"}, bus.drop_cnt, m_drop);
      chk({tag, "_writes_left"}, wq.size(), 0);
      chk({tag, "_frame_ok_left"}, okq.size(), 0);
   endtask

   task automatic run(input string tag, input int sent, input int er_at);
      predict(sent, er_at);
      send(sent, er_at, NONE);
      frame_end(tag);
   endtask

   always @(negedge clk125) begin
      if (bus.wr_en === 1'b1) begin
         if (wq.size() != 0) begin
            we = wq.pop_front();
            chk("write", {bus.wr_ad, bus.wr_data}, we);
         end else if (loose) chk("write_bank", bus.wr_ad[10], !bus.idx);
         else begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got ad=%0h data=%0h, required no write", bus.wr_ad, bus.wr_data);
         end
      end
      if (bus.frame_ok === 1'b1) begin
         if (okq.size() != 0) begin
            oe = okq.pop_front();
            chk("frame_ok_idx_seq", {bus.idx, bus.seq}, oe);
         end else begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_frame_ok: got idx=%0d seq=%0h, required no pulse", bus.idx, bus.seq);
         end
      end
   end

   initial begin
      int kind, sent, er;
      bus.rxctl = 1'b0;
      bus.rxd   = 4'h0;
      repeat (3) @(posedge clk125);
      #1 reset_chk();
      rst_n = 1'b1;
      idle(4);

      build(16'h1234, 8'h59, 8'h19, 0);
      run("good", 1052, NONE);
      build(16'h0001, 8'h59, 8'h19, 1);
      predict(1052, NONE);
      send(1052, NONE, NONE);
      build(16'h0002, 8'h59, 8'h19, 1);
      run("b2b", 1052, NONE);
      build(16'h7777, 8'h59, 8'h19, 0);
      fr[24+500] = fr[24+500] ^ 8'hff;
      run("crc_err", 1052, NONE);
      build(16'h4444, 8'h58, 8'h19, 0);
      run("dst_bad", 1052, NONE);
      build(16'h5555, 8'h59, 8'h18, 0);
      run("etype_bad", 1052, NONE);
      build(16'h6666, 8'h59, 8'h19, 0);
      run("short", 24 + 301, NONE);
      build(16'h0abc, 8'h59, 8'h19, 1);
      run("after_short", 1052, NONE);

      for (int r = 0; r < 8; r++) begin
         kind = $urandom_range(0, 4);
         sent = 1052;
         er   = NONE;
         build(16'($urandom), 8'h59, 8'h19, 1);
         if (kind == 1) fr[24 + $urandom_range(0, 1023)] ^= 8'(1 << $urandom_range(0, 7));
         if (kind == 2) sent = 1053;
         if (kind == 3) er = 24 + $urandom_range(0, 1023);
         if (kind == 4) sent = $urandom_range(25, 1051);
         run("random", sent, er);
      end

      m_idx  = 1'b0;
      m_seq  = '0;
      m_drop = '0;
      m_crc  = '0;
      loose  = 1'b1;
      build(16'h9999, 8'h59, 8'h19, 0);
      send(1052, NONE, 24 + 100);
      frame_end("reset_frame");
      loose = 1'b0;
      build(16'h2222, 8'h59, 8'h19, 1);
      run("after_reset", 1052, NONE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
